mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous memory between the pipeline's instruction-fetch (IF) and data-memory (DM) stages, so the core can run against a unified memory.
- Grants one transaction at a time. Each transaction drives the memory port for one cycle, waits a fixed memory latency, then returns data with a one-cycle ready pulse.
- Produces per-port stall signals that feed the pipeline hazard control.
- Sits between the pipeline stages and the unified memory inside Top.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_starve_ctr.sv | 32 +++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/DM unified-memory port arbiter.
package mem_arb_pkg;

  localparam int ARB_ADDR_W     = 32;
  localparam int ARB_DATA_W     = 32;
  localparam int ARB_MEM_LAT    = 2;
  localparam int ARB_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  // Bits needed to hold values 0..maxval (never less than one bit).
  function automatic int cnt_width(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts DM grants made while IF is waiting; forces the next grant to IF at STARVE_MAX.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic dm_grant_i,
  input  logic if_grant_i,
  input  logic if_req_i,
  input  logic idle_entry_i,
  output logic force_if_o
);

  localparam int CNT_W = cnt_width(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (if_grant_i || (idle_entry_i && !if_req_i)) begin
      cnt_q <= '0;
    end else if (dm_grant_i && if_req_i && !force_if_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign force_if_o = (cnt_q == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and DM stages onto one single-port synchronous memory, one transaction at a time.
// Optional IF anti-starvation counter is enabled by defining ARB_FAIRNESS_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int MEM_LAT    = ARB_MEM_LAT,
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              dm_stall_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int LAT_W = cnt_width(MEM_LAT - 1);

  arb_state_e        state_q;
  arb_owner_e        owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LAT_W-1:0]  cnt_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic              if_ready_q;
  logic              dm_ready_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic              force_if;
  logic              start_d;
  logic              grant_dm_d;
  arb_owner_e        owner_d;
  logic [ADDR_W-1:0] addr_d;
  logic              we_d;
  logic [DATA_W-1:0] wdata_d;
  logic              done;

  assign start_d    = (state_q == IDLE) && (if_req_i || dm_req_i);
  assign grant_dm_d = dm_req_i && !(force_if && if_req_i);
  assign done       = (state_q == WAIT) && (cnt_q == '0);

  always_comb begin
    owner_d = OWN_IF;
    addr_d  = if_addr_i;
    we_d    = 1'b0;
    wdata_d = '0;
    if (grant_dm_d) begin
      owner_d = OWN_DM;
      addr_d  = dm_addr_i;
      we_d    = dm_we_i;
      wdata_d = dm_wdata_i;
    end
  end

`ifdef ARB_FAIRNESS_EN
  logic dm_grant;
  logic if_grant;

  assign dm_grant = start_d && grant_dm_d;
  assign if_grant = start_d && !grant_dm_d;

  mem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .dm_grant_i   (dm_grant),
    .if_grant_i   (if_grant),
    .if_req_i     (if_req_i),
    .idle_entry_i (done),
    .force_if_o   (force_if)
  );
`else
  // Strict DM priority: IF is never forced ahead of a pending DM request.
  assign force_if = 1'b0 & (STARVE_MAX > 0);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_d) begin
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            mem_en_q <= 1'b1;
            mem_we_q <= we_d;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          cnt_q    <= LAT_W'(MEM_LAT - 1);
          state_q  <= WAIT;
        end
        WAIT: begin
          if (cnt_q == '0) begin
            // Writes complete with a ready pulse but leave dm_rdata untouched.
            if (owner_q == OWN_DM) begin
              dm_ready_q <= 1'b1;
              if (!we_q) dm_rdata_q <= mem_rdata_i;
            end else begin
              if_ready_q <= 1'b1;
              if_rdata_q <= mem_rdata_i;
            end
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_ready_o  = if_ready_q;
  assign dm_ready_o  = dm_ready_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_stall_o  = if_req_i && !if_ready_q;
  assign dm_stall_o  = dm_req_i && !dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level arbitration model.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 4;
`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  localparam int M_RAND = 0;
  localparam int M_HOLD = 1;
  localparam int M_OFF  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] dm_wdata, if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic          if_ready, if_stall, dm_ready, dm_stall, mem_en, mem_we;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata),
    .if_ready_o(if_ready), .if_stall_o(if_stall),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(dm_rdata), .dm_ready_o(dm_ready), .dm_stall_o(dm_stall),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 16) ? 32'h0000_0013 : 32'h1000_0007 + 32'(i) * 32'h0001_0101;
  endfunction

  // Synchronous memory environment: read data held until the next access.
  logic [31:0] mem [64];
  logic [31:0] mem_rdata_r = '0;
  bit          mem_loaded  = 1'b0;
  assign mem_rdata = mem_rdata_r;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
      else        mem_rdata_r <= mem[mem_addr[7:2]];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [64];
  int          edge_n = 0;
  bit          m_pending = 1'b0;
  int          m_ready_edge = 0, m_free_edge = 0, m_starve = 0;
  bit          m_owner_dm, m_we;
  logic [31:0] m_addr, m_wdata, m_data;
  logic        e_mem_en = 0, e_mem_we = 0, e_if_ready = 0, e_dm_ready = 0;
  logic [31:0] e_mem_addr = '0, e_mem_wdata = '0, e_if_rdata = '0, e_dm_rdata = '0;
  int          if_mode = M_OFF, dm_mode = M_OFF;
  int          n_if_rdy = 0, n_dm_rdy = 0, n_mem_en = 0;
  int          last_en_edge = 0, last_if_rdy_edge = 0, last_dm_rdy_edge = 0;

  task automatic model_edge();
    bit pick_dm;
    edge_n++;
    e_if_ready = 0; e_dm_ready = 0; e_mem_en = 0; e_mem_we = 0;
    if (m_pending && edge_n == m_ready_edge) begin
      if (m_owner_dm) begin
        e_dm_ready = 1;
        if (!m_we) e_dm_rdata = m_data;
      end else begin
        e_if_ready = 1;
        e_if_rdata = m_data;
      end
      m_pending = 0;
      if (!if_req) m_starve = 0;
    end
    if (!m_pending && edge_n >= m_free_edge && (if_req || dm_req)) begin
      pick_dm = dm_req && !(FAIR && m_starve >= SMAX && if_req);
      m_owner_dm = pick_dm;
      if (pick_dm) begin
        m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
        if (if_req) m_starve++;
      end else begin
        m_addr = if_addr; m_we = 0; m_wdata = '0;
        m_starve = 0;
      end
      if (m_we) ref_mem[m_addr[7:2]] = m_wdata;
      else      m_data = ref_mem[m_addr[7:2]];
      m_pending    = 1;
      m_ready_edge = edge_n + LAT + 1;
      m_free_edge  = edge_n + LAT + 2;
      e_mem_en = 1; e_mem_we = m_we; e_mem_addr = m_addr; e_mem_wdata = m_wdata;
    end
  endtask

  function automatic logic [31:0] rand_if_addr();
    return 32'($urandom_range(0, 47)) << 2;
  endfunction
  function automatic logic [31:0] rand_dm_addr();
    return 32'h40 + (32'($urandom_range(0, 47)) << 2);
  endfunction

  task automatic gen_inputs();
    if (!(if_req && !e_if_ready)) begin
      case (if_mode)
        M_HOLD:  begin if_req = 1; if_addr = rand_if_addr(); end
        M_OFF:   if_req = 0;
        default: begin if_req = ($urandom_range(0, 2) != 0); if_addr = rand_if_addr(); end
      endcase
    end
    if (!(dm_req && !e_dm_ready)) begin
      case (dm_mode)
        M_HOLD:  dm_req = 1;
        M_OFF:   dm_req = 0;
        default: dm_req = ($urandom_range(0, 2) != 0);
      endcase
      dm_addr  = rand_dm_addr();
      dm_we    = $urandom_range(0, 1);
      dm_wdata = $urandom;
    end
  endtask

  task automatic compare_all();
    check("mem_en", mem_en, e_mem_en);
    check("mem_we", mem_we, e_mem_we);
    if (e_mem_en) begin
      check("mem_addr", mem_addr, e_mem_addr);
      if (e_mem_we) check("mem_wdata", mem_wdata, e_mem_wdata);
    end
    check("if_ready", if_ready, e_if_ready);
    check("dm_ready", dm_ready, e_dm_ready);
    check("if_rdata", if_rdata, e_if_rdata);
    check("dm_rdata", dm_rdata, e_dm_rdata);
    check("if_stall", if_stall, if_req & ~e_if_ready);
    check("dm_stall", dm_stall, dm_req & ~e_dm_ready);
    if (mem_en)   begin n_mem_en++; last_en_edge = edge_n; end
    if (if_ready) begin n_if_rdy++; last_if_rdy_edge = edge_n; end
    if (dm_ready) begin n_dm_rdy++; last_dm_rdy_edge = edge_n; end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    gen_inputs();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drain(input int max_cycles);
    int k = 0;
    do begin
      cycle();
      k++;
    end while ((m_pending || if_req || dm_req) && k < max_cycles);
    if (m_pending || if_req || dm_req) check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int s, en0, rdy0, base, k;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    rst_n = 0; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;

    // Reset state, then a DM read abandoned mid-WAIT by reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_ready", if_ready, 0);
    check("rst_dm_ready", dm_ready, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_if_stall", if_stall, 0);
    rst_n = 1; dm_req = 1; dm_addr = 32'h10;
    @(posedge clk); @(negedge clk);
    check("pre_rst_en", mem_en, 1);
    check("pre_rst_addr", mem_addr, 32'h10);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 0; #1;
    check("async_mem_en", mem_en, 0);
    check("async_mem_addr", mem_addr, 0);
    check("async_dm_ready", dm_ready, 0);
    check("async_dm_rdata", dm_rdata, 0);
    check("async_dm_stall", dm_stall, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); @(negedge clk);
    check("accept_after_rst", mem_en, 1);
    check("no_ready_after_rst", dm_ready, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      check("no_stale_ready", dm_ready, 0);
    end
    @(posedge clk); @(negedge clk);
    check("dm_ready_after_rst", dm_ready, 1);
    check("dm_rdata_after_rst", dm_rdata, init_word(4));
    dm_req = 0;
    e_dm_rdata = init_word(4);

    // IF-only fetch from 0x40.
    if_mode = M_OFF; dm_mode = M_OFF;
    if_req = 1; if_addr = 32'h40;
    drain(40);
    check("if_latency", 32'(last_if_rdy_edge - last_en_edge), 32'(LAT + 1));
    check("if_rdata_0x40", if_rdata, 32'h13);

    // Simultaneous requests: DM write first, then IF.
    if_req = 1; if_addr = 32'h44;
    dm_req = 1; dm_we = 1; dm_addr = 32'h80; dm_wdata = 32'hDEAD_BEEF;
    s = edge_n + 1;
    drain(40);
    check("dm_first_lat", 32'(last_dm_rdy_edge - s), 32'(LAT + 1));
    check("if_after_dm_lat", 32'(last_if_rdy_edge - s), 32'(2 * LAT + 3));
    check("mem_0x80", mem[32], 32'hDEAD_BEEF);

    // DM held high across its ready cycles: back-to-back transactions.
    en0 = n_mem_en; rdy0 = n_dm_rdy;
    dm_mode = M_HOLD;
    k = 0;
    while (n_dm_rdy - rdy0 < 4 && k < 60) begin cycle(); k++; end
    check("dm_b2b_done", 32'(n_dm_rdy - rdy0 >= 4), 1);
    dm_mode = M_OFF;
    drain(40);
    check("en_per_txn", 32'(n_mem_en - en0), 32'(n_dm_rdy - rdy0));

    // Both held continuously for 50 transactions.
    base = n_if_rdy + n_dm_rdy; rdy0 = n_if_rdy;
    if_mode = M_HOLD; dm_mode = M_HOLD;
    if_req = 1; if_addr = rand_if_addr();
    dm_req = 1; dm_addr = rand_dm_addr(); dm_we = 0; dm_wdata = $urandom;
    k = 0;
    while (n_if_rdy + n_dm_rdy - base < 50 && k < 400) begin cycle(); k++; end
    check("both_held_if_grants", 32'(n_if_rdy - rdy0), FAIR ? 32'd10 : 32'd0);
    if_mode = M_OFF; dm_mode = M_OFF;
    drain(40);

    // Random traffic.
    if_mode = M_RAND; dm_mode = M_RAND;
    repeat (3000) cycle();
    if_mode = M_OFF; dm_mode = M_OFF;
    drain(100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
